dual_fetch_unit: RTL and testbench

Two-wide instruction fetch stage for the out-of-order RISC-V core. It drives the two fetch PCs (`fakepc1`, `fakepc2`) into the combinational instruction memory and captures the returned `fakeinstr1`/`fakeinstr2` pair. Each fetched pair is buffered, together with its PCs, in a circular fetch queue. The queue hands up to two instructions per cycle, in order, to decode, and is flushed on a redirect from the branch/commit logic.

---
 rtl/dual_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_dual_fetch_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dual_fetch_unit.sv
// dual_fetch_unit
//   Two-wide instruction fetch stage. Presents a pair of sequential PCs to a
//   combinational instruction memory, buffers each returned pair (with PCs)
//   in a circular fetch queue and hands up to two entries per cycle, in
//   order, to decode. A redirect flushes the queue and restarts fetch.
//
//   Optional feature macro: FETCH_PERF_EN adds the perf_fetched counter port.
//
// Ports
//   clk           in   clock, all state updates on rising edge
//   reset         in   asynchronous active-high reset
//   fakepc1       out  PC of fetch slot 0 (registered)
//   fakepc2       out  fakepc1 + 4
//   fakeinstr1    in   instruction at fakepc1 (same cycle)
//   fakeinstr2    in   instruction at fakepc2 (same cycle)
//   redirect_val  in   flush queue and restart fetch at redirect_pc
//   redirect_pc   in   restart target, bits [1:0] ignored
//   deq_num       in   entries taken by decode this cycle (3 acts as 2)
//   deq_val0/1    out  head / head+1 entry valid
//   deq_pc0/1     out  PCs of head / head+1 entry
//   deq_instr0/1  out  instructions of head / head+1 entry
//   perf_fetched  out  (FETCH_PERF_EN only) instructions enqueued, mod 2^32

module dual_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h200,
   parameter int unsigned DEPTH    = 8
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] fakepc1,
   output logic [31:0] fakepc2,
   input  logic [31:0] fakeinstr1,
   input  logic [31:0] fakeinstr2,
   input  logic        redirect_val,
   input  logic [31:0] redirect_pc,
   input  logic [1:0]  deq_num,
   output logic        deq_val0,
   output logic        deq_val1,
   output logic [31:0] deq_pc0,
   output logic [31:0] deq_pc1,
   output logic [31:0] deq_instr0,
   output logic [31:0] deq_instr1
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched
`endif
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [31:0]   pc_q, pc_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW-1:0] head_p1, tail_p1;
   logic [CW-1:0] count_q, count_d;

   logic [31:0]   q_pc    [DEPTH];
   logic [31:0]   q_instr [DEPTH];

   logic          enq;
   logic [1:0]    deq_req;
   logic [1:0]    deq_eff;

   // Low address bits of the redirect target are discarded by design.
   logic          unused_rpc;
   assign unused_rpc = ^redirect_pc[1:0];

   assign head_p1 = head_q + PW'(1);
   assign tail_p1 = tail_q + PW'(1);

   assign fakepc1 = pc_q;
   assign fakepc2 = pc_q + 32'd4;

   assign deq_val0   = (count_q != '0);
   assign deq_val1   = (count_q >= CW'(2));
   assign deq_pc0    = q_pc[head_q];
   assign deq_pc1    = q_pc[head_p1];
   assign deq_instr0 = q_instr[head_q];
   assign deq_instr1 = q_instr[head_p1];

   always_comb begin
      deq_req = (deq_num == 2'd3) ? 2'd2 : deq_num;
      // Requests beyond the valid entries are clamped; count_q <= 1 here.
      if (count_q < CW'(deq_req)) begin
         deq_eff = count_q[1:0];
      end else begin
         deq_eff = deq_req;
      end
      // Room is judged on the pre-dequeue occupancy.
      enq = !redirect_val && (count_q <= CW'(DEPTH - 2));

      pc_d    = pc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;

      if (redirect_val) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(deq_eff);
         count_d = count_q - CW'(deq_eff);
         if (enq) begin
            tail_d  = tail_q + PW'(2);
            count_d = count_d + CW'(2);
            pc_d    = pc_q + 32'd8;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         pc_q    <= pc_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Queue storage needs no reset: entries are only read once counted valid.
   always_ff @(posedge clk) begin
      if (enq && !reset) begin
         q_pc[tail_q]     <= fakepc1;
         q_instr[tail_q]  <= fakeinstr1;
         q_pc[tail_p1]    <= fakepc2;
         q_instr[tail_p1] <= fakeinstr2;
      end
   end

`ifdef FETCH_PERF_EN
   logic [31:0] perf_q;

   // Survives redirects; only reset clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_q <= '0;
      end else if (enq) begin
         perf_q <= perf_q + 32'd2;
      end
   end

   assign perf_fetched = perf_q;
`endif

endmodule

// File: tb/tb_dual_fetch_unit.sv
// Self-checking bench for dual_fetch_unit. A behavioural instruction memory
// answers the fetch PCs; a scoreboard queue collects the entries expected to
// be enqueued and is compared against the dequeue outputs every cycle.

module tb_dual_fetch_unit;

   localparam int unsigned DEPTH = 8;
   localparam logic [31:0] RST_PC = 32'h200;

   logic        clk;
   logic        reset;
   logic [31:0] fakepc1, fakepc2;
   logic [31:0] fakeinstr1, fakeinstr2;
   logic        redirect_val;
   logic [31:0] redirect_pc;
   logic [1:0]  deq_num;
   logic        deq_val0, deq_val1;
   logic [31:0] deq_pc0, deq_pc1, deq_instr0, deq_instr1;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
`endif

   int tests_run;
   int tests_failed;

   // Scoreboard and reference state.
   logic [31:0] sb_pc[$];
   logic [31:0] sb_instr[$];
   logic [31:0] model_pc;
   logic [31:0] model_perf;

   dual_fetch_unit #(
      .RESET_PC (RST_PC),
      .DEPTH    (DEPTH)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .fakepc1      (fakepc1),
      .fakepc2      (fakepc2),
      .fakeinstr1   (fakeinstr1),
      .fakeinstr2   (fakeinstr2),
      .redirect_val (redirect_val),
      .redirect_pc  (redirect_pc),
      .deq_num      (deq_num),
      .deq_val0     (deq_val0),
      .deq_val1     (deq_val1),
      .deq_pc0      (deq_pc0),
      .deq_pc1      (deq_pc1),
      .deq_instr0   (deq_instr0),
      .deq_instr1   (deq_instr1)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_of(input logic [31:0] a);
      if (a == 32'h200) return 32'h00200093;
      if (a == 32'h204) return 32'h00300113;
      return {a[15:0] ^ 16'hA5C3, a[17:2]};
   endfunction

   assign fakeinstr1 = mem_of(fakepc1);
   assign fakeinstr2 = mem_of(fakepc2);

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all();
      int n;
      n = sb_pc.size();
      check_val("fakepc1", fakepc1, model_pc);
      check_val("fakepc2", fakepc2, model_pc + 32'd4);
      check_val("deq_val0", {31'd0, deq_val0}, {31'd0, n >= 1});
      check_val("deq_val1", {31'd0, deq_val1}, {31'd0, n >= 2});
      if (n >= 1) begin
         check_val("deq_pc0", deq_pc0, sb_pc[0]);
         check_val("deq_instr0", deq_instr0, sb_instr[0]);
      end
      if (n >= 2) begin
         check_val("deq_pc1", deq_pc1, sb_pc[1]);
         check_val("deq_instr1", deq_instr1, sb_instr[1]);
      end
`ifdef FETCH_PERF_EN
      check_val("perf_fetched", perf_fetched, model_perf);
`endif
   endtask

   task automatic model_init();
      sb_pc.delete();
      sb_instr.delete();
      model_pc   = RST_PC;
      model_perf = 32'd0;
   endtask

   // Asserts reset at the current time, checks outputs without any edge,
   // then releases it at the next falling edge.
   task automatic do_reset();
      reset        = 1'b1;
      redirect_val = 1'b0;
      redirect_pc  = 32'd0;
      deq_num      = 2'd0;
      #1;
      model_init();
      compare_all();
      @(negedge clk);
      reset = 1'b0;
   endtask

   // One cycle: drive at the falling edge, check, then advance the model on
   // the rising edge.
   task automatic step(input logic [1:0] dn, input logic rv, input logic [31:0] rpc);
      int n, req, d;
      deq_num      = dn;
      redirect_val = rv;
      redirect_pc  = rpc;
      #1;
      compare_all();
      @(posedge clk);
      n = sb_pc.size();
      if (rv) begin
         sb_pc.delete();
         sb_instr.delete();
         model_pc = {rpc[31:2], 2'b00};
      end else begin
         req = (dn == 2'd3) ? 2 : int'(dn);
         d   = (req < n) ? req : n;
         for (int i = 0; i < d; i++) begin
            void'(sb_pc.pop_front());
            void'(sb_instr.pop_front());
         end
         if (n <= DEPTH - 2) begin
            sb_pc.push_back(model_pc);
            sb_instr.push_back(mem_of(model_pc));
            sb_pc.push_back(model_pc + 32'd4);
            sb_instr.push_back(mem_of(model_pc + 32'd4));
            model_pc   = model_pc + 32'd8;
            model_perf = model_perf + 32'd2;
         end
      end
      @(negedge clk);
      redirect_val = 1'b0;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      redirect_val = 1'b0;
      redirect_pc  = 32'd0;
      deq_num      = 2'd0;
      model_init();

      // Reset then fill with no dequeue.
      do_reset();
      for (int i = 0; i < 6; i++) step(2'd0, 1'b0, 32'd0);
      check_val("fill_pc_hold", fakepc1, 32'h220);
      check_val("fill_head_pc", deq_pc0, 32'h200);
      check_val("fill_instr0", deq_instr0, 32'h00200093);
      check_val("fill_instr1", deq_instr1, 32'h00300113);
`ifdef FETCH_PERF_EN
      check_val("perf_after_fill", perf_fetched, 32'd8);
`endif

      // Full queue, single dequeue per cycle.
      for (int i = 0; i < 10; i++) step(2'd1, 1'b0, 32'd0);

      // Refill, then redirect while full with deq_num = 2.
      for (int i = 0; i < 4; i++) step(2'd0, 1'b0, 32'd0);
      step(2'd2, 1'b1, 32'h248);
      check_val("redir_fakepc1", fakepc1, 32'h248);
      check_val("redir_val0", {31'd0, deq_val0}, 32'd0);
      step(2'd2, 1'b0, 32'd0);
      check_val("redir_deq_pc0", deq_pc0, 32'h248);

      // Streaming two per cycle, including deq_num = 3.
      for (int i = 0; i < 10; i++) step(2'd2, 1'b0, 32'd0);
      for (int i = 0; i < 4; i++) step(2'd3, 1'b0, 32'd0);

      // Misaligned redirect and PC wrap.
      step(2'd2, 1'b1, 32'h20A);
      check_val("misalign_pc", fakepc1, 32'h208);
      step(2'd2, 1'b1, 32'hFFFFFFFC);
      check_val("wrap_fakepc2", fakepc2, 32'h0);
      step(2'd2, 1'b0, 32'd0);
      check_val("wrap_next_pc", fakepc1, 32'h4);
      for (int i = 0; i < 3; i++) step(2'd1, 1'b0, 32'd0);

      // Random traffic with occasional redirects.
      for (int i = 0; i < 80; i++) begin
         logic        rv;
         logic [31:0] rpc;
         rv  = ($urandom_range(0, 15) == 0);
         rpc = $urandom;
         step(2'($urandom_range(0, 3)), rv, rpc);
      end

      // Asynchronous reset mid-stream with five entries held.
      do_reset();
      for (int i = 0; i < 4; i++) step(2'd0, 1'b0, 32'd0);
      step(2'd1, 1'b0, 32'd0);
      step(2'd2, 1'b0, 32'd0);
      check_val("pre_reset_count", sb_pc.size(), 32'd5);
      check_val("pre_reset_val0", {31'd0, deq_val0}, 32'd1);
      deq_num = 2'd0;
      #2;
      reset = 1'b1;
      #1;
      check_val("async_val0", {31'd0, deq_val0}, 32'd0);
      check_val("async_fakepc1", fakepc1, 32'h200);
`ifdef FETCH_PERF_EN
      check_val("async_perf", perf_fetched, 32'd0);
`endif
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 6; i++) step(2'd2, 1'b0, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
